// File: rtl/keypad_scanner_if.sv
// Pin-side bundle of the keypad scanner: column sense in, row drive and key report out.
interface keypad_scanner_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
);
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);

    logic [COLS-1:0]   col_in;
    logic [ROWS-1:0]   row_out;
    logic [CODE_W-1:0] key_code;
    logic              kp_bar;
    logic              key_valid;
    logic              multi_key;

    modport master (
        input  col_in,
        output row_out,
        output key_code,
        output kp_bar,
        output key_valid,
        output multi_key
    );

    modport slave (
        output col_in,
        input  row_out,
        input  key_code,
        input  kp_bar,
        input  key_valid,
        input  multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// Row-scanning keypad front end: walking-zero row drive, synchronised column sense,
// two-way debounce and registered key report (code, held flag, press strobe, multi flag).
module keypad_scanner #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 4,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);
    localparam int unsigned CODE_W = $clog2(ROWS * COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned NL_W   = $clog2(COLS + 1);
    localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE + 1);

    localparam logic [1:0] S_SCAN      = 2'd0;
    localparam logic [1:0] S_DEB_PRESS = 2'd1;
    localparam logic [1:0] S_PRESSED   = 2'd2;
    localparam logic [1:0] S_DEB_REL   = 2'd3;

    logic [COLS-1:0]   col_s1_q, col_s2_q;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tick;

    logic [1:0]        state_q, state_d;
    logic [ROW_W-1:0]  row_q, row_d, row_next;
    logic [CODE_W-1:0] cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] key_code_q, key_code_d;
    logic              kp_bar_q, kp_bar_d;
    logic              key_valid_q, key_valid_d;
    logic              multi_q, multi_d;
    logic [ROWS-1:0]   row_out_q, row_out_d;

    logic [NL_W-1:0]   n_low;
    logic [COL_W-1:0]  col_idx;
    logic [CODE_W-1:0] sample_code;
    logic              is_none, is_single, is_multi, rel_like;

    // Two-flop column synchroniser and free-running scan divider
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_s1_q <= '1;
            col_s2_q <= '1;
            div_q    <= '0;
        end else begin
            col_s1_q <= kp.col_in;
            col_s2_q <= col_s1_q;
            div_q    <= div_d;
        end
    end

    assign tick  = (div_q == DIV_W'(SCAN_DIV - 1));
    assign div_d = tick ? '0 : div_q + DIV_W'(1);

    // Count low columns; col_idx is only meaningful for a single-low sample
    always_comb begin
        n_low   = '0;
        col_idx = '0;
        for (int c = 0; c < COLS; c++) begin
            if (!col_s2_q[c]) begin
                n_low   = n_low + NL_W'(1);
                col_idx = COL_W'(c);
            end
        end
    end

    assign is_none     = (n_low == '0);
    assign is_single   = (n_low == NL_W'(1));
    assign is_multi    = (n_low > NL_W'(1));
    assign sample_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(col_idx);
    // A different single key on the frozen row means the held key has gone
    assign rel_like    = is_none | (is_single & (sample_code != cand_q));
    assign row_next    = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_SCAN;
            row_q       <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            kp_bar_q    <= 1'b1;
            key_valid_q <= 1'b0;
            multi_q     <= 1'b0;
            row_out_q   <= ~(ROWS'(1));
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            kp_bar_q    <= kp_bar_d;
            key_valid_q <= key_valid_d;
            multi_q     <= multi_d;
            row_out_q   <= row_out_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        kp_bar_d    = kp_bar_q;
        key_valid_d = 1'b0;
        multi_d     = multi_q;

        if (tick) begin
            multi_d = is_multi;
            case (state_q)
                S_SCAN: begin
                    if (is_single) begin
                        cand_d = sample_code;
                        cnt_d  = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            state_d     = S_PRESSED;
                            key_code_d  = sample_code;
                            kp_bar_d    = 1'b0;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = S_DEB_PRESS;
                        end
                    end else begin
                        row_d = row_next;
                    end
                end
                S_DEB_PRESS: begin
                    if (is_single && (sample_code == cand_q)) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                            state_d     = S_PRESSED;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            kp_bar_d    = 1'b0;
                            key_valid_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                        row_d   = row_next;
                    end
                end
                S_PRESSED: begin
                    if (rel_like) begin
                        if (DEBOUNCE == 1) begin
                            state_d  = S_SCAN;
                            cnt_d    = '0;
                            kp_bar_d = 1'b1;
                            row_d    = row_next;
                        end else begin
                            state_d = S_DEB_REL;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                S_DEB_REL: begin
                    if (rel_like) begin
                        if (cnt_q == CNT_W'(DEBOUNCE - 1)) begin
                            state_d  = S_SCAN;
                            cnt_d    = '0;
                            kp_bar_d = 1'b1;
                            row_d    = row_next;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = S_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign row_out_d    = ~(ROWS'(1) << row_d);

    assign kp.row_out   = row_out_q;
    assign kp.key_code  = key_code_q;
    assign kp.kp_bar    = kp_bar_q;
    assign kp.key_valid = key_valid_q;
    assign kp.multi_key = multi_q;
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Clocked, parametrised keypad front end that replaces the combinational key encoder. It drives a walking-zero pattern onto an ROWS×COLS active-low matrix and synchronises and samples the column lines. Each press is debounced in both directions, then reported as a binary key code with a held active-low press flag and a one-cycle press strobe. It sits between the keypad pins and the safe-lock code-entry logic.

## Interface
- ROWS, 4, number of driven row lines (≥2)
- COLS, 4, number of sensed column lines (≥2)
- SCAN_DIV, 4, clock cycles each row is driven before its columns are sampled (≥4)
- DEBOUNCE, 3, consecutive matching samples needed to accept a press or a release (≥1)
- CODE_W, $clog2(ROWS*COLS), key code width (derived; not overridden)
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- col_in  in  COLS  raw column lines, active low, asynchronous to clk
- row_out  out  ROWS  walking-zero row drive; exactly one bit low at all times
- key_code  out  CODE_W  row*COLS + col of the accepted key; holds its last value after release
- kp_bar  out  1  active low while a debounced key is held
- key_valid  out  1  one-cycle high pulse when a press is accepted
- multi_key  out  1  high after any sample with more than one column low in the driven row

## Operation
- **Column synchroniser:** col_in passes through a 2-FF synchroniser (reset value all ones). All decisions use the synchronised value.
- **Tick:** a divide counter runs 0..SCAN_DIV-1 continuously. A tick is the cycle with count = SCAN_DIV-1. Sampling happens only on ticks.
- **Sample classification:**
  - none: all columns high.
  - single: exactly one column c low; candidate = r*COLS + c, where r is the driven row.
  - multi: two or more columns low. multi_key is set on a multi sample and cleared on any non-multi sample.
- **States:** SCAN, DEB_PRESS, PRESSED, DEB_REL.
  - SCAN: tick with none or multi → advance row (ROWS-1 wraps to 0). Tick with single → latch candidate, debounce count = 1, go DEB_PRESS with the row frozen. If DEBOUNCE = 1, go directly to PRESSED.
  - DEB_PRESS: tick with single and same candidate → count+1; when count reaches DEBOUNCE → PRESSED. Any other sample → SCAN, advancing to the next row.
  - PRESSED: on entry, key_code ← candidate, kp_bar ← 0, key_valid pulses. Tick with single (same key) or multi → stay. Tick with none → release count = 1, go DEB_REL. If DEBOUNCE = 1, release immediately.
  - DEB_REL: tick with none → count+1; when count reaches DEBOUNCE → kp_bar ← 1, go SCAN, advancing the row. Tick with same single or multi → back to PRESSED with no new key_valid. Tick with a different single → treated as none.
- A key is never re-reported while held. A new key_valid requires a full debounced release followed by a fresh debounced press.
- The row stays frozen in DEB_PRESS, PRESSED and DEB_REL. Keys on other rows are ignored until SCAN resumes.

## Timing
- **Reset values:** row_out = ~1 (row 0 low), key_code = 0, kp_bar = 1, key_valid = 0, multi_key = 0, state SCAN, row index 0, divide and debounce counters 0. Reset mid-press is immediate and behaves the same way.
- All outputs are registered and update the cycle after the deciding tick.
- row_out changes the cycle after a tick. Two sync cycles plus SCAN_DIV ≥ 4 guarantee that the next sample reflects the new row.
- **Press latency:** when a key goes stable while its row is driven, key_valid rises one cycle after the DEBOUNCE-th consecutive tick sample, counting the first detecting tick. Worst-case latency from press adds a full scan, ROWS*SCAN_DIV cycles.
- **Release latency:** kp_bar rises one cycle after the DEBOUNCE-th consecutive none tick.
- key_valid and the kp_bar falling edge occur in the same cycle. key_code is valid from that cycle onward.

## Test plan
- **Reset:** assert rst_n = 0 for 3 cycles with col_in held at 4'b0000 → row_out = 4'b1110, kp_bar = 1, key_valid = 0, key_code = 0, multi_key = 0. Release reset → rows walk 1110→1101→1011→0111→1110, one step every 4 cycles.
- **Clean press:** model a matrix with key (row 2, col 1) pressed, defaults in place → exactly one key_valid pulse, key_code = 9, kp_bar = 0 while held. Release → kp_bar = 1 three ticks later. row_out is frozen at 1011 throughout.
- **Bounce:** toggle the key every 2 ticks for 10 ticks, then hold → no key_valid during the bounce, a single key_valid with key_code = 9 after 3 stable ticks. Bounce on release → no extra pulse.
- **Multi-key:** press (1,0) and (1,3) together → multi_key = 1, no key_valid, scanning continues. Release (1,3) → multi_key = 0, key_valid with key_code = 4.
- **Wrap and corners:** press (3,3), then release, then press (0,0) → key_code = 15, then key_code = 0. The row index wraps from 3 to 0 with no missed row.
- **Reset mid-press:** hold key 6 until kp_bar = 0, then pulse rst_n low for 1 cycle → all outputs return to reset values. With the key still held, a new key_valid with key_code = 6 follows after debounce.
